// File: rtl/dp_pipe_pkg.sv
// dp_pipe_pkg -- shared types and constants for the dp_pipe_stage datapath
// pipeline register.
//   WIDTH_DEF / REGW_DEF / CNTW_DEF : default field and counter widths
//   beat_t       : one beat (d0, d1, d2) at the default widths
//   skid_state_e : occupancy of the skid variant (EMPTY, ONE, TWO)
//   beat_bits()  : flattened beat width for arbitrary WIDTH/REGW
//   stall_sat()  : saturation value of a CNTW-bit stall counter
package dp_pipe_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int REGW_DEF  = 4;
  localparam int CNTW_DEF  = 16;

  typedef struct packed {
    logic [WIDTH_DEF-1:0] d0;
    logic [WIDTH_DEF-1:0] d1;
    logic [REGW_DEF-1:0]  d2;
  } beat_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  function automatic int beat_bits(input int width, input int regw);
    return 2 * width + regw;
  endfunction

  // All-ones value of a cntw-bit counter (wraps correctly for cntw = 64).
  function automatic logic [63:0] stall_sat(input int unsigned cntw);
    return (64'd1 << cntw) - 64'd1;
  endfunction

endpackage

// File: rtl/dp_pipe_if.sv
// dp_pipe_if -- valid/ready beat channel between datapath stages.
//   valid : beat present (producer -> consumer)
//   ready : consumer accepts beat this cycle (consumer -> producer)
//   d0/d1 : WIDTH-bit data fields
//   d2    : REGW-bit register-index field
// Modports: master = producer side, slave = consumer side.
interface dp_pipe_if #(
  parameter int WIDTH = 32,
  parameter int REGW  = 4
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [REGW-1:0]  d2;

  modport master (output valid, d0, d1, d2, input  ready);
  modport slave  (input  valid, d0, d1, d2, output ready);
endinterface

// File: rtl/dp_skid_buf.sv
// dp_skid_buf -- one-entry holding register for the skid variant of
// dp_pipe_stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture d
//   unload     : entry handed on downstream; entry returns to zero
//   clear      : squash; entry returns to zero (wins over load)
//   d / q      : BW-bit flattened beat in / held beat out
module dp_skid_buf #(
  parameter int BW = 68
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          unload,
  input  logic          clear,
  input  logic [BW-1:0] d,
  output logic [BW-1:0] q
);
  logic [BW-1:0] beat_d, beat_q;

  // Zeroing on unload keeps a retired or squashed beat from lingering.
  always_comb begin
    // NOTE: default first so every path assigns beat_d -- no latch.
    beat_d = beat_q;
    if (clear || unload) beat_d = '0;
    else if (load)       beat_d = d;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) beat_q <= '0;
    else        beat_q <= beat_d;
  end

  assign q = beat_q;
endmodule

// File: rtl/dp_pipe_stage.sv
// dp_pipe_stage -- parametrised valid/ready pipeline register carrying two
// WIDTH-bit data fields and a REGW-bit register index, with synchronous
// flush and a saturating stall counter.
//   clk       : clock, all state on rising edge
//   reset     : asynchronous active-low reset
//   flush     : synchronous squash of every beat held in the stage
//   up        : dp_pipe_if.slave  -- upstream beats in (up.ready = in_ready)
//   dn        : dp_pipe_if.master -- registered beats out
//   stall_cnt : saturating count of cycles with dn.valid=1 and dn.ready=0
// Build option DP_PIPE_SKID_EN: adds a one-entry skid buffer so that
// up.ready is driven from state only (no path from dn.ready). Without it
// up.ready = dn.ready | !dn.valid.
module dp_pipe_stage
  import dp_pipe_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int REGW  = REGW_DEF,
  parameter int CNTW  = CNTW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  dp_pipe_if.slave        up,
  dp_pipe_if.master       dn,
  output logic [CNTW-1:0] stall_cnt
);
  localparam int              BW        = beat_bits(WIDTH, REGW);
  localparam logic [CNTW-1:0] STALL_MAX = CNTW'(stall_sat(CNTW));

  logic [BW-1:0]   in_beat;
  logic [BW-1:0]   out_beat_d, out_beat_q;
  logic            out_valid_d, out_valid_q;
  logic            in_ready, accept, issue;
  logic [CNTW-1:0] stall_cnt_d, stall_cnt_q;

  assign in_beat             = {up.d0, up.d1, up.d2};
  assign accept              = up.valid & in_ready;
  assign issue               = out_valid_q & dn.ready;
  assign up.ready            = in_ready;
  assign dn.valid            = out_valid_q;
  assign {dn.d0, dn.d1, dn.d2} = out_beat_q;
  assign stall_cnt           = stall_cnt_q;

`ifdef DP_PIPE_SKID_EN
  skid_state_e   state_d, state_q;
  logic          skid_load, skid_unload, skid_clear;
  logic [BW-1:0] skid_beat;

  // Ready depends only on the state register.
  assign in_ready = (state_q != TWO);

  dp_skid_buf #(.BW(BW)) u_skid (
    .clk    (clk),
    .rst_n  (reset),
    .load   (skid_load),
    .unload (skid_unload),
    .clear  (skid_clear),
    .d      (in_beat),
    .q      (skid_beat)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_beat_d  = out_beat_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;
    if (flush) begin
      state_d     = EMPTY;
      out_valid_d = 1'b0;
      out_beat_d  = '0;
      skid_clear  = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: if (accept) begin
          state_d     = ONE;
          out_valid_d = 1'b1;
          out_beat_d  = in_beat;
        end
        ONE: begin
          if (accept && issue) begin
            out_beat_d = in_beat;          // replace retired beat, no bubble
          end else if (accept) begin
            state_d   = TWO;               // output stalled: park in skid
            skid_load = 1'b1;
          end else if (issue) begin
            state_d     = EMPTY;
            out_valid_d = 1'b0;            // fields keep last value
          end
        end
        TWO: if (issue) begin
          state_d     = ONE;
          out_beat_d  = skid_beat;         // skid beat advances same edge
          skid_unload = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= EMPTY;
    else        state_q <= state_d;
  end
`else
  // Ready when the output register frees up this cycle or is already empty.
  assign in_ready = dn.ready | ~out_valid_q;

  always_comb begin
    out_valid_d = out_valid_q;
    out_beat_d  = out_beat_q;
    if (flush) begin
      out_valid_d = 1'b0;
      out_beat_d  = '0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_beat_d  = in_beat;
    end else if (issue) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  // Counts every stalled cycle, flush or not; only reset clears it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !dn.ready && (stall_cnt_q != STALL_MAX))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_beat_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_beat_q  <= out_beat_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_dp_pipe_stage.sv
// tb_dp_pipe_stage -- directed, scoreboard-checked bench for dp_pipe_stage
// (CNTW=4 so saturation is reachable). Expectations follow the build option
// DP_PIPE_SKID_EN when it is defined.
module tb_dp_pipe_stage;
  import dp_pipe_pkg::*;

`ifdef DP_PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam int CNTW = 4;
  localparam int SAT  = 15;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic [CNTW-1:0] stall_cnt;

  dp_pipe_if #(.WIDTH(WIDTH_DEF), .REGW(REGW_DEF)) up_if ();
  dp_pipe_if #(.WIDTH(WIDTH_DEF), .REGW(REGW_DEF)) dn_if ();

  dp_pipe_stage #(.WIDTH(WIDTH_DEF), .REGW(REGW_DEF), .CNTW(CNTW)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .up        (up_if.slave),
    .dn        (dn_if.master),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_errors = 0;
  beat_t sb[$];
  int    exp_stall = 0;
  bit    last_acc;
  bit    seen_55 = 1'b0;
  int    n_acc;
  int    flush_stall;
  logic [31:0] nxt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [3:0] d2, input bit rdy, input bit fl);
    up_if.valid = v;
    up_if.d0    = d0;
    up_if.d1    = d1;
    up_if.d2    = d2;
    dn_if.ready = rdy;
    flush       = fl;
  endtask

  // Called at a falling edge with inputs already driven: checks handshake
  // state against the scoreboard, updates it, advances one clock.
  task automatic tick();
    bit    exp_rdy, acc, iss;
    beat_t head, b;
    #1;
    exp_rdy = SKID ? (sb.size() < 2) : ((sb.size() == 0) || dn_if.ready);
    check("out_valid", dn_if.valid, sb.size() != 0);
    check("in_ready", up_if.ready, exp_rdy);
    if (dn_if.valid && dn_if.d0 == 32'h55) seen_55 = 1'b1;
    acc = up_if.valid && exp_rdy;
    iss = (sb.size() != 0) && dn_if.ready;
    if ((sb.size() != 0) && !dn_if.ready && exp_stall != SAT) exp_stall++;
    last_acc = 1'b0;
    if (flush) begin
      sb.delete();
    end else begin
      if (iss) begin
        head = sb.pop_front();
        check("issue_d0", dn_if.d0, head.d0);
        check("issue_d1", dn_if.d1, head.d1);
        check("issue_d2", dn_if.d2, head.d2);
      end
      if (acc) begin
        b.d0 = up_if.d0; b.d1 = up_if.d1; b.d2 = up_if.d2;
        sb.push_back(b);
        last_acc = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("stall_cnt", stall_cnt, exp_stall);
  endtask

  initial begin
    // ---- reset values ----
    reset = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    @(negedge clk); @(negedge clk);
    check("rst_out_valid", dn_if.valid, 1'b0);
    check("rst_d0", dn_if.d0, 32'h0);
    check("rst_d1", dn_if.d1, 32'h0);
    check("rst_d2", dn_if.d2, 4'h0);
    check("rst_stall", stall_cnt, 0);
    reset = 1'b1;
    #1;
    check("rst_in_ready", up_if.ready, 1'b1);
    @(negedge clk);

    // ---- single beat ----
    drive(1'b1, 32'hDEADBEEF, 32'h12345678, 4'hA, 1'b1, 1'b0);
    tick();
    check("single_valid", dn_if.valid, 1'b1);
    check("single_d0", dn_if.d0, 32'hDEADBEEF);
    check("single_d1", dn_if.d1, 32'h12345678);
    check("single_d2", dn_if.d2, 4'hA);
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    tick();
    check("single_done_valid", dn_if.valid, 1'b0);
    check("single_hold_d0", dn_if.d0, 32'hDEADBEEF);

    // ---- streaming, no bubbles ----
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(i), ~32'(i), 4'(i), 1'b1, 1'b0);
      tick();
      check("stream_d0", dn_if.d0, 32'(i));
    end
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    tick();

    // ---- back-pressure ----
    drive(1'b1, 32'h100, 32'h1, 4'h1, 1'b1, 1'b0);
    tick();
    nxt   = 32'h200;
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, nxt, 32'h2, 4'h2, 1'b0, 1'b0);
      tick();
      if (last_acc) begin n_acc++; nxt = nxt + 32'h100; end
      check("bp_hold_d0", dn_if.d0, 32'h100);
      check("bp_hold_valid", dn_if.valid, 1'b1);
    end
    check("bp_stall5", stall_cnt, 5);
    check("bp_extra_accepts", n_acc, SKID ? 1 : 0);
    check("bp_in_ready_low", up_if.ready, 1'b0);
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    tick();
    check("bp_release_d0", dn_if.d0, SKID ? 32'h200 : 32'h100);
    tick();
    tick();

    // ---- flush with a beat offered while full ----
    drive(1'b1, 32'h11, 32'h11, 4'h1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h22, 32'h22, 4'h2, 1'b0, 1'b0);
    tick();
    flush_stall = exp_stall;
    drive(1'b1, 32'h55, 32'h55, 4'h5, 1'b1, 1'b1);
    tick();
    check("flush_valid", dn_if.valid, 1'b0);
    check("flush_d0", dn_if.d0, 32'h0);
    check("flush_d1", dn_if.d1, 32'h0);
    check("flush_d2", dn_if.d2, 4'h0);
    check("flush_stall_kept", stall_cnt, flush_stall);
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    check("flush_no_55", seen_55, 1'b0);

    // ---- saturation ----
    drive(1'b1, 32'h77, 32'h77, 4'h7, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    check("sat_stall", stall_cnt, SAT);
    check("sat_hold_d0", dn_if.d0, 32'h77);

    // ---- async reset mid-stall, checked before the next rising edge ----
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", dn_if.valid, 1'b0);
    check("arst_d0", dn_if.d0, 32'h0);
    check("arst_d1", dn_if.d1, 32'h0);
    check("arst_d2", dn_if.d2, 4'h0);
    check("arst_stall", stall_cnt, 0);
    sb.delete();
    exp_stall = 0;
    @(negedge clk);
    reset = 1'b1;

    // ---- recovery ----
    drive(1'b1, 32'hCAFEF00D, 32'h0BADC0DE, 4'h3, 1'b1, 1'b0);
    tick();
    check("recover_d0", dn_if.d0, 32'hCAFEF00D);
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dp_pipe_stage.md
# dp_pipe_stage

Parametrised pipeline stage register for the processor datapath, the successor to the fixed three-field inter-stage register. Carries two WIDTH-bit data fields and one REGW-bit register-index field, and adds a valid/ready handshake, synchronous flush for hazard squashing, and a saturating stall counter. Sits between any two datapath stages (e.g. EX→MEM, MEM→WB). Back-pressure propagates upstream.

## Interface
- WIDTH, 32, width of data fields d0/d1
- REGW, 4, width of register-index field d2
- CNTW, 16, width of stall counter
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately
- flush  in  1  synchronous squash of every beat held in the stage
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage accepts beat this cycle
- in_d0  in  WIDTH  data field 0
- in_d1  in  WIDTH  data field 1
- in_d2  in  REGW  register-index field
- out_valid  out  1  beat presented downstream
- out_ready  in  1  downstream accepts beat
- out_d0  out  WIDTH  registered field 0
- out_d1  out  WIDTH  registered field 1
- out_d2  out  REGW  registered field 2
- stall_cnt  out  CNTW  cycles with out_valid=1 and out_ready=0

## Operation
- Reset (reset=0): out_valid=0, out_d0/out_d1/out_d2=0, stall_cnt=0, skid entry empty; in_ready=1 after reset release.
- Accept: in_valid & in_ready at a clock edge loads the beat.
- Issue: out_valid & out_ready at an edge retires the head beat.
- Simultaneous accept and issue: the new beat replaces the retired one; out_valid stays 1; no bubble.
- Stall: out_valid & !out_ready holds out_d* and out_valid stable; stall_cnt increments.
- stall_cnt saturates at 2^CNTW-1. It is cleared only by reset, not by flush.
- Flush (flush=1 at an edge): has priority over accept and issue. out_valid=0, all out_d* cleared to 0, skid emptied. A beat offered that cycle is dropped. in_ready is unaffected by flush in the same cycle.
- Data fields are zero whenever out_valid=0 after reset or flush. After a plain issue with no refill they hold their last value.
- No arithmetic: fields pass through unmodified, bit-exact.

## Timing
- Latency: 1 cycle from accept to out_valid=1 with an empty stage.
- Throughput: 1 beat/cycle while out_ready=1.
- Without skid: in_ready = out_ready | !out_valid (combinational path from out_ready).
- With skid: in_ready is a registered signal with no combinational dependence on out_ready.
  - States: EMPTY, ONE (output register valid), TWO (output and skid valid). in_ready = (state != TWO).
  - EMPTY→ONE on accept.
  - ONE→TWO on accept without issue.
  - ONE→EMPTY on issue without accept.
  - TWO→ONE on issue; the skid beat moves to the output register the same edge. No accept is possible in TWO.
  - Any state→EMPTY on flush.
- Reset assertion mid-transfer discards all beats asynchronously. Outputs go to their reset values without waiting for clk.

## Configuration
- DP_PIPE_SKID_EN defined: one-entry skid buffer and the 3-state FSM above. in_ready is registered. Full throughput with a registered ready.
- DP_PIPE_SKID_EN undefined: single output register only. in_ready is combinational as stated. Behaviour is otherwise identical, including flush and stall_cnt.

## Structure
- Package dp_pipe_pkg holds:
  - typedef of the beat struct (d0, d1, d2), parametrised via WIDTH/REGW defaults;
  - skid FSM state enum (EMPTY, ONE, TWO);
  - constant for the stall_cnt saturation value.
- One sub-module, dp_skid_buf: a one-entry holding register with load/unload/clear, instantiated only under DP_PIPE_SKID_EN.

## Test plan
- Reset then single beat: release reset, in_valid=1, d0=0xDEADBEEF, d1=0x12345678, d2=0xA, out_ready=1 → next cycle out_valid=1 with identical fields. The following cycle (in_valid=0) → out_valid=0.
- Streaming: 8 consecutive beats with d0=0..7 and out_ready held 1 → out_d0 shows 0..7 on consecutive cycles, no bubbles, in_ready constantly 1.
- Back-pressure: out_ready=0 for 5 cycles with a beat held → out fields stable and stall_cnt=5.
  - With skid: exactly one further beat is accepted, then in_ready=0.
  - After out_ready returns to 1: both beats issue in order.
- Flush with accept: flush=1 with in_valid=1, d0=0x55 while the stage is full → next cycle out_valid=0, out_d0=0, and beat 0x55 never appears; stall_cnt unchanged.
- Saturation: CNTW=4, out_ready=0 for 20 cycles → stall_cnt stops at 15.
- Async reset mid-stall: drive reset=0 between clock edges → out_valid=0, fields=0, and stall_cnt=0 immediately, before the next clk edge.
